// File: rtl/operand_loader.sv
// Byte-stream loader: assembles six little-endian operands from framed bytes in shadow
// registers and publishes them atomically, holding them until the consumer acknowledges.
module operand_loader #(
    parameter int unsigned bus_width = 32
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic               in_ready,
    output logic [bus_width:0] a,
    output logic [bus_width:0] b,
    output logic [bus_width:0] enf,
    output logic [bus_width:0] load,
    output logic [bus_width:0] qtd,
    output logic [bus_width:0] base,
    output logic               out_valid,
    input  logic               out_ack,
    output logic               frame_err
);

    localparam int unsigned OpW  = bus_width + 1;
    localparam int unsigned NB   = (OpW + 7) / 8;
    localparam int unsigned SW   = NB * 8;
    localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StHold} state_t;

    state_t                 state;
    logic [CntW-1:0]        byte_cnt;
    logic [2:0]             op_idx;
    logic [5:0][SW-1:0]     shadow;
    logic [5:0][SW-1:0]     shadow_d;
    logic                   accept;
    logic                   wr_en;
    logic                   last_byte;
    logic [2:0]             wr_op;
    logic [CntW-1:0]        wr_byte;
    logic [2:0]             nxt_op;
    logic [CntW-1:0]        nxt_byte;

    assign in_ready  = (state != StHold);
    assign accept    = in_valid & in_ready;
    // A start-of-frame byte always lands at (a, byte 0), both from IDLE and as a restart.
    assign wr_en     = accept & (in_sof | (state == StLoad));
    assign wr_op     = in_sof ? 3'd0 : op_idx;
    assign wr_byte   = in_sof ? '0 : byte_cnt;
    assign last_byte = (state == StLoad) && !in_sof && (op_idx == 3'd5)
                       && (byte_cnt == CntW'(NB - 1));

    always_comb begin
        if (wr_byte == CntW'(NB - 1)) begin
            nxt_byte = '0;
            nxt_op   = wr_op + 3'd1;
        end else begin
            nxt_byte = wr_byte + CntW'(1);
            nxt_op   = wr_op;
        end
    end

    // Shadow view including the byte being accepted, so completion can publish it directly.
    always_comb begin
        shadow_d = shadow;
        if (wr_en) begin
            for (int i = 0; i < 6; i++) begin
                for (int k = 0; k < int'(NB); k++) begin
                    if (wr_op == 3'(i) && wr_byte == CntW'(k)) begin
                        shadow_d[i][8*k +: 8] = in_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            byte_cnt  <= '0;
            op_idx    <= '0;
            shadow    <= '0;
            a         <= '0;
            b         <= '0;
            enf       <= '0;
            load      <= '0;
            qtd       <= '0;
            base      <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (wr_en) begin
                shadow <= shadow_d;
            end
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        if (in_sof) begin
                            byte_cnt <= nxt_byte;
                            op_idx   <= nxt_op;
                            state    <= StLoad;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (in_sof) begin
                            frame_err <= 1'b1;
                        end
                        if (last_byte) begin
                            a         <= shadow_d[0][OpW-1:0];
                            b         <= shadow_d[1][OpW-1:0];
                            enf       <= shadow_d[2][OpW-1:0];
                            load      <= shadow_d[3][OpW-1:0];
                            qtd       <= shadow_d[4][OpW-1:0];
                            base      <= shadow_d[5][OpW-1:0];
                            out_valid <= 1'b1;
                            byte_cnt  <= '0;
                            op_idx    <= '0;
                            state     <= StHold;
                        end else begin
                            byte_cnt <= nxt_byte;
                            op_idx   <= nxt_op;
                        end
                    end
                end
                StHold: begin
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed frames plus randomized frames, gaps and
// acknowledges, checked against a byte-array model of the expected operands.
module tb_operand_loader;

    localparam int unsigned BW = 32;
    localparam int NB = 5;
    localparam int FL = 6 * NB;

    logic          sysclk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          in_ready;
    logic [BW:0]   a, b, enf, load, qtd, base;
    logic          out_valid;
    logic          out_ack = 1'b0;
    logic          frame_err;

    int passes = 0;
    int total = 0;
    logic [7:0] frame [FL];

    operand_loader #(.bus_width(BW)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .enf      (enf),
        .load     (load),
        .qtd      (qtd),
        .base     (base),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .frame_err(frame_err)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Operand idx is the little-endian concatenation of its NB bytes, truncated to BW+1 bits.
    function automatic logic [BW:0] exp_op(int idx);
        logic [8*NB-1:0] v;
        v = '0;
        for (int k = 0; k < NB; k++) v = v | ({{(8*NB-8){1'b0}}, frame[idx*NB+k]} << (8*k));
        return v[BW:0];
    endfunction

    function automatic logic [BW:0] dut_op(int idx);
        case (idx)
            0: return a;
            1: return b;
            2: return enf;
            3: return load;
            4: return qtd;
            default: return base;
        endcase
    endfunction

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s);
        in_data  = d;
        in_sof   = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
    endtask

    task automatic fill_ref();
        for (int i = 0; i < FL; i++) frame[i] = 8'hFF;
        frame[0] = 8'h01; frame[1] = 8'h00; frame[2] = 8'h00; frame[3] = 8'h00; frame[4] = 8'h01;
    endtask

    task automatic fill_random();
        for (int i = 0; i < FL; i++) frame[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_ops(input string tag);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (dut_op(i) !== exp_op(i))
                $display("FAIL %s op%0d: got %h expected %h", tag, i, dut_op(i), exp_op(i));
            else passes++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || frame_err !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_ctrl: got ov=%b fe=%b rdy=%b expected 0 0 1",
                     out_valid, frame_err, in_ready);
        else passes++;
        for (int i = 0; i < FL; i++) frame[i] = 8'h00;
        check_ops("reset_ops");
        reset = 1'b1;
        step();
    endtask

    task automatic test_full_frame();
        fill_ref();
        for (int i = 0; i < FL - 1; i++) send_byte(frame[i], i == 0);
        total++;
        if (out_valid !== 1'b0 || a !== '0)
            $display("FAIL partial_frame: got ov=%b a=%h expected 0 0", out_valid, a);
        else passes++;
        send_byte(frame[FL-1], 1'b0);
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL full_frame_done: got ov=%b rdy=%b expected 1 0", out_valid, in_ready);
        else passes++;
        total++;
        if (a !== 33'h1_0000_0001 || b !== 33'h1_FFFF_FFFF || base !== 33'h1_FFFF_FFFF)
            $display("FAIL full_frame_const: got a=%h b=%h base=%h expected 100000001 1ffffffff",
                     a, b, base);
        else passes++;
        check_ops("full_frame");
        do_ack();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL full_frame_ack: got ov=%b rdy=%b expected 0 1", out_valid, in_ready);
        else passes++;
        check_ops("retain_after_ack");
    endtask

    task automatic test_backpressure();
        fill_random();
        for (int i = 0; i < FL; i++) send_byte(frame[i], i == 0);
        in_valid = 1'b1;
        in_sof   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_data = 8'($urandom_range(0, 255));
            in_sof  = 1'($urandom_range(0, 1));
            step();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || frame_err !== 1'b0)
                $display("FAIL backpressure_hold c%0d: got ov=%b rdy=%b fe=%b expected 1 0 0",
                         c, out_valid, in_ready, frame_err);
            else passes++;
        end
        in_sof = 1'b0;
        check_ops("backpressure_stable");
        out_ack = 1'b1;
        step();
        in_valid = 1'b0;
        out_ack  = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL backpressure_release: got ov=%b rdy=%b expected 0 1", out_valid, in_ready);
        else passes++;
        check_ops("backpressure_retain");
    endtask

    task automatic test_stray();
        out_ack = 1'b1;
        send_byte(8'hA5, 1'b0);
        out_ack = 1'b0;
        total++;
        if (frame_err !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL stray_err: got fe=%b rdy=%b ov=%b expected 1 1 0",
                     frame_err, in_ready, out_valid);
        else passes++;
        step();
        total++;
        if (frame_err !== 1'b0)
            $display("FAIL stray_pulse_width: got fe=%b expected 0", frame_err);
        else passes++;
        check_ops("stray_no_change");
        fill_random();
        for (int i = 0; i < FL; i++) send_byte(frame[i], i == 0);
        total++;
        if (out_valid !== 1'b1)
            $display("FAIL stray_then_frame: got ov=%b expected 1", out_valid);
        else passes++;
        check_ops("stray_then_frame");
        do_ack();
    endtask

    task automatic test_restart();
        fill_random();
        for (int i = 0; i < 12; i++) send_byte(frame[i], i == 0);
        fill_random();
        send_byte(frame[0], 1'b1);
        total++;
        if (frame_err !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL restart_err: got fe=%b ov=%b expected 1 0", frame_err, out_valid);
        else passes++;
        for (int i = 1; i < FL - 1; i++) send_byte(frame[i], 1'b0);
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL restart_early: got ov=%b expected 0", out_valid);
        else passes++;
        send_byte(frame[FL-1], 1'b0);
        total++;
        if (out_valid !== 1'b1 || frame_err !== 1'b0)
            $display("FAIL restart_done: got ov=%b fe=%b expected 1 0", out_valid, frame_err);
        else passes++;
        check_ops("restart_ops");
        do_ack();
    endtask

    task automatic test_reset_mid();
        fill_random();
        for (int i = 0; i < 17; i++) send_byte(frame[i], i == 0);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || frame_err !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_mid_ctrl: got ov=%b fe=%b rdy=%b expected 0 0 1",
                     out_valid, frame_err, in_ready);
        else passes++;
        for (int i = 0; i < FL; i++) frame[i] = 8'h00;
        check_ops("reset_mid_async");
        step();
        reset = 1'b1;
        step();
        send_byte(8'h3C, 1'b0);
        total++;
        if (frame_err !== 1'b1)
            $display("FAIL reset_mid_needs_sof: got fe=%b expected 1", frame_err);
        else passes++;
        fill_random();
        for (int i = 0; i < FL; i++) send_byte(frame[i], i == 0);
        total++;
        if (out_valid !== 1'b1)
            $display("FAIL reset_mid_reload: got ov=%b expected 1", out_valid);
        else passes++;
        check_ops("reset_mid_reload");
        do_ack();
    endtask

    task automatic test_gapped();
        fill_ref();
        for (int i = 0; i < FL; i++) begin
            send_byte(frame[i], i == 0);
            if (i < FL - 1) begin
                total++;
                if (out_valid !== 1'b0)
                    $display("FAIL gapped_early byte%0d: got ov=%b expected 0", i, out_valid);
                else passes++;
                step();
            end
        end
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL gapped_done: got ov=%b rdy=%b expected 1 0", out_valid, in_ready);
        else passes++;
        check_ops("gapped");
        do_ack();
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            fill_random();
            for (int i = 0; i < FL; i++) begin
                out_ack = 1'($urandom_range(0, 1));
                send_byte(frame[i], i == 0);
                out_ack = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            total++;
            if (out_valid !== 1'b1)
                $display("FAIL random_done f%0d: got ov=%b expected 1", f, out_valid);
            else passes++;
            check_ops("random");
            repeat ($urandom_range(0, 3)) step();
            total++;
            if (out_valid !== 1'b1)
                $display("FAIL random_hold f%0d: got ov=%b expected 1", f, out_valid);
            else passes++;
            do_ack();
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_stray();
        test_restart();
        test_reset_mid();
        test_gapped();
        test_random();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
